// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: ALU op codes, arbiter FSM states
// and the bit positions of the NZVC flags inside rsp_flags.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ILL1   = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110,
    OP_ILL7   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic logic op_is_legal(input alu_op_e op);
    return !((op == OP_ILL1) || (op == OP_ILL7));
  endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU with an explicit ripple-carry adder chain.
// Illegal op codes yield a zero result (so Z is set) and raise err.
module alu
  import alu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  alu_op_e     op,
  output logic [63:0] result,
  output logic [3:0]  flags,
  output logic        err
);

  logic [64:0] carry;
  logic [63:0] b_eff;
  logic [63:0] sum;
  logic        is_arith;

  always_comb begin
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    // SUB is A + ~B + 1, so carry out means "no borrow"
    b_eff    = (op == OP_SUB) ? ~b : b;
    carry    = '0;
    sum      = '0;
    carry[0] = (op == OP_SUB);
    for (int i = 0; i < 64; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    err = !op_is_legal(op);
    case (op)
      OP_PASS_B: result = b;
      OP_ADD,
      OP_SUB:    result = sum;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      default:   result = '0;
    endcase

    flags         = '0;
    flags[FLAG_N] = result[63];
    flags[FLAG_Z] = (result == '0);
    if (is_arith) begin
      flags[FLAG_V] = carry[63] ^ carry[64];
      flags[FLAG_C] = carry[64];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around, returned both one-hot and as a binary index.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin grant, operands held
// for EXEC_CYCLES, then an id-tagged valid/ready response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int EXEC_CYCLES = 2,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  output logic [N_REQ-1:0]  req_ready,
  input  logic [N_REQ*64-1:0] req_a,
  input  logic [N_REQ*64-1:0] req_b,
  input  logic [N_REQ*3-1:0]  req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [63:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  arb_state_e       state, next_state;
  logic [63:0]      op_a, op_b;
  alu_op_e          op_code;
  logic [ID_W-1:0]  op_id;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  rr_ptr;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [63:0]      alu_result;
  logic [3:0]       alu_flags;
  logic             alu_err;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The ALU only ever sees the latched operands, so requesters may change theirs freely
  alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .flags  (alu_flags),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = EXEC;
      EXEC:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gated by rst_n so no grant is advertised while reset is held
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n) req_ready = grant;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= OP_PASS_B;
      op_id      <= '0;
      cnt        <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          op_a    <= req_a[64*grant_idx +: 64];
          op_b    <= req_b[64*grant_idx +: 64];
          op_code <= alu_op_e'(req_op[3*grant_idx +: 3]);
          op_id   <= grant_idx;
          cnt     <= CNT_W'(EXEC_CYCLES - 1);
          rr_ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= op_id;
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_err    <= alu_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
